// File: rtl/pipeline_pkg.sv
// Shared RV64 pipeline types: EX/MEM and MEM/WB register layouts, LSU FSM states, load/store size codes.
package pipeline_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] RES_LOAD = 2'b01;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RD
  } lsu_state_e;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic            MemWrite;
    logic [2:0]      funct3;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] RD2;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rd;
  } exmem_t;

  typedef struct packed {
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] ImmExt;
    logic [XLEN-1:0] PCPlus4;
    logic [4:0]      Rd;
  } memwb_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store byte enables/data, load extraction with sign/zero extension,
// and natural-alignment detection. Lanes shifted beyond byte 7 are dropped.
module lsu_align
  import pipeline_pkg::*;
(
  input  logic [2:0]      addr_off_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [63:0]     rdata_i,
  output logic [7:0]      be_o,
  output logic [63:0]     wdata_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            misaligned_o
);

  logic [7:0]  be_base;
  logic [5:0]  bit_off;
  logic [63:0] shifted;

  assign bit_off = {addr_off_i, 3'b000};

  always_comb begin
    be_base = 8'h01;
    unique case (funct3_i[1:0])
      SZ_B: be_base = 8'h01;
      SZ_H: be_base = 8'h03;
      SZ_W: be_base = 8'h0F;
      SZ_D: be_base = 8'hFF;
      default: be_base = 8'h01;
    endcase
  end

  assign be_o    = be_base << addr_off_i;
  assign wdata_o = rd2_i << bit_off;
  assign shifted = rdata_i >> bit_off;

  always_comb begin
    load_data_o = '0;
    unique case (funct3_i)
      F3_LB:   load_data_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   load_data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   load_data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   load_data_o = shifted;
      F3_LBU:  load_data_o = {56'd0, shifted[7:0]};
      F3_LHU:  load_data_o = {48'd0, shifted[15:0]};
      F3_LWU:  load_data_o = {32'd0, shifted[31:0]};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    misaligned_o = 1'b0;
    unique case (funct3_i[1:0])
      SZ_B: misaligned_o = 1'b0;
      SZ_H: misaligned_o = addr_off_i[0];
      SZ_W: misaligned_o = |addr_off_i[1:0];
      SZ_D: misaligned_o = |addr_off_i;
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: req/gnt/rvalid data-memory handshake, stall generation and the MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN drops misaligned accesses without issuing them and pulses misalign_o.
module mem_stage_lsu
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  exmem_t          exmem_i,
  output memwb_t          memwb_o,
  output logic            stall_o,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [63:0]     dmem_wdata,
  output logic [7:0]      dmem_be,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [63:0]     dmem_rdata,
  output logic            misalign_o
);

  lsu_state_e      state_q, state_d;
  memwb_t          memwb_q, memwb_d;
  logic            misalign_q;

  logic            is_load, is_store, mem_op;
  logic            req, complete, done, trap_hit;
  logic            misaligned;
  logic [XLEN-1:0] load_data;

  assign is_store = exmem_i.MemWrite;
  assign is_load  = ~exmem_i.MemWrite & (exmem_i.ResultSrc == RES_LOAD);
  assign mem_op   = is_store | is_load;

  lsu_align u_align (
    .addr_off_i   (exmem_i.ALUResult[2:0]),
    .funct3_i     (exmem_i.funct3),
    .rd2_i        (exmem_i.RD2),
    .rdata_i      (dmem_rdata),
    .be_o         (dmem_be),
    .wdata_o      (dmem_wdata),
    .load_data_o  (load_data),
    .misaligned_o (misaligned)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_hit = mem_op & misaligned & (state_q == IDLE);
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap_hit          = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !trap_hit) begin
          req = 1'b1;
          if (dmem_gnt) begin
            if (is_store) complete = 1'b1;
            else          state_d  = WAIT_RD;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (dmem_gnt) begin
          if (is_store) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = complete | trap_hit;
  assign stall_o   = ~reset & mem_op & ~done;
  assign dmem_req  = ~reset & req;
  assign dmem_we   = is_store;
  assign dmem_addr = exmem_i.ALUResult;

  // Stalled, non-completing edges push a bubble so writeback sees nothing twice.
  always_comb begin
    memwb_d = '0;
    if (!mem_op || done) begin
      memwb_d.RegWrite  = exmem_i.RegWrite & ~trap_hit;
      memwb_d.ResultSrc = exmem_i.ResultSrc;
      memwb_d.ALUResult = exmem_i.ALUResult;
      memwb_d.load_data = (is_load && !trap_hit) ? load_data : '0;
      memwb_d.ImmExt    = exmem_i.ImmExt;
      memwb_d.PCPlus4   = exmem_i.PCPlus4;
      memwb_d.Rd        = exmem_i.Rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      memwb_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      memwb_q    <= memwb_d;
      misalign_q <= trap_hit;
    end
  end

  assign memwb_o    = memwb_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu with a byte-level reference model and a scripted memory responder.
module tb_mem_stage_lsu;
  import pipeline_pkg::*;

  localparam int CW = $bits(memwb_t);

  logic            clk = 1'b0;
  logic            reset;
  exmem_t          exmem_i;
  memwb_t          memwb_o;
  logic            stall_o;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [63:0]     dmem_wdata;
  logic [7:0]      dmem_be;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [63:0]     dmem_rdata;
  logic            misalign_o;

  int n_checks = 0;
  int n_pass   = 0;

  mem_stage_lsu dut (
    .clk         (clk),
    .reset       (reset),
    .exmem_i     (exmem_i),
    .memwb_o     (memwb_o),
    .stall_o     (stall_o),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .misalign_o  (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: access is n bytes starting at byte o; bytes beyond lane 7 do not exist.
  function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [2:0] o, input logic [63:0] rd);
    int n = 1 << f3[1:0];
    int oi = int'(o);
    logic [63:0] v = '0;
    if (f3 == 3'b111) return '0;
    for (int i = 0; i < n; i++)
      if (oi + i < 8) v[8*i +: 8] = rd[8*(oi+i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  function automatic logic [7:0] exp_be(input logic [2:0] f3, input logic [2:0] o);
    int n = 1 << f3[1:0];
    int oi = int'(o);
    logic [7:0] b = '0;
    for (int i = 0; i < n; i++)
      if (oi + i < 8) b[oi+i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [2:0] o, input logic [63:0] d);
    int oi = int'(o);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++)
      if (oi + i < 8) w[8*(oi+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  // kind: 0 = ALU op, 1 = load, 2 = store. g = cycles until gnt, r = cycles from gnt to rvalid.
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] rd2, input logic [63:0] rdat, input int g, input int r);
    exmem_t ex;
    memwb_t exp_wb;
    int     total;
    int     rs;
    bit     last;
    bit     exp_req;
    rs           = $urandom_range(0, 2);
    ex.RegWrite  = 1'($urandom);
    ex.ResultSrc = (kind == 1) ? 2'b01 : (rs == 0) ? 2'b00 : (rs == 1) ? 2'b10 : 2'b11;
    ex.MemWrite  = (kind == 2);
    ex.funct3    = f3;
    ex.ALUResult = addr;
    ex.RD2       = rd2;
    ex.ImmExt    = {$urandom, $urandom};
    ex.PCPlus4   = {$urandom, $urandom};
    ex.Rd        = 5'($urandom);

    exp_wb.RegWrite  = ex.RegWrite;
    exp_wb.ResultSrc = ex.ResultSrc;
    exp_wb.ALUResult = addr;
    exp_wb.load_data = (kind == 1) ? exp_load(f3, addr[2:0], rdat) : '0;
    exp_wb.ImmExt    = ex.ImmExt;
    exp_wb.PCPlus4   = ex.PCPlus4;
    exp_wb.Rd        = ex.Rd;

    total   = (kind == 0) ? 1 : (kind == 2) ? g + 1 : g + r + 1;
    exmem_i = ex;
    for (int k = 0; k < total; k++) begin
      last        = (k == total - 1);
      dmem_gnt    = (kind != 0 && k == g) ? 1'b1 :
                    (kind == 0 || (kind == 1 && k > g)) ? 1'($urandom) : 1'b0;
      dmem_rvalid = (kind == 1 && k == g + r) ? 1'b1 :
                    (kind != 1) ? 1'($urandom) : 1'b0;
      dmem_rdata  = (kind == 1 && last) ? rdat : {$urandom, $urandom};
      exp_req     = (kind == 2) || (kind == 1 && k <= g);
      @(negedge clk);
      check("stall", stall_o, !last);
      check("req", dmem_req, exp_req);
      check("misalign", misalign_o, 1'b0);
      if (exp_req) begin
        check("addr", dmem_addr, addr);
        check("we", dmem_we, kind == 2);
      end
      if (kind == 2) begin
        check("be", dmem_be, exp_be(f3, addr[2:0]));
        check("wdata", dmem_wdata, exp_wdata(addr[2:0], rd2));
      end
      @(posedge clk);
      #1;
      check("memwb", memwb_o, last ? exp_wb : memwb_t'('0));
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #12;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    exmem_t ld_ex;
    int     kind;
    reset       = 1'b1;
    exmem_i     = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    #12;
    check("rst_memwb", memwb_o, '0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req", dmem_req, 1'b0);
    check("rst_misalign", misalign_o, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_op(0, 3'b000, 64'h1234, 64'h0, 64'h0, 0, 0);
    check("alu_result", memwb_o.ALUResult, 64'h1234);
    check("alu_load_data", memwb_o.load_data, 64'h0);

    run_op(1, 3'b000, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 2);
    check("lb_sext", memwb_o.load_data, 64'hFFFF_FFFF_FFFF_FF80);
    run_op(1, 3'b100, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, 2);
    check("lbu_zext", memwb_o.load_data, 64'h80);

    run_op(2, 3'b001, 64'h6, 64'hBEEF, 64'h0, 2, 0);
    run_op(2, 3'b011, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
    run_op(1, 3'b011, 64'h18, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 1);
    check("ld_full", memwb_o.load_data, 64'hDEAD_BEEF_CAFE_F00D);
    run_op(2, 3'b010, 64'h2, 64'h1122_3344, 64'h0, 0, 0);
    run_op(1, 3'b101, 64'h7, 64'h0, 64'hAB00_0000_0000_0000, 1, 1);
    check("lhu_trunc", memwb_o.load_data, 64'hAB);

    // Abort a load sitting in WAIT_RD with reset; a later rvalid must not complete anything.
    ld_ex           = '0;
    ld_ex.RegWrite  = 1'b1;
    ld_ex.ResultSrc = RES_LOAD;
    ld_ex.funct3    = 3'b011;
    ld_ex.ALUResult = 64'h40;
    ld_ex.Rd        = 5'd9;
    exmem_i  = ld_ex;
    dmem_gnt = 1'b1;
    @(posedge clk);
    #1;
    dmem_gnt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("abort_memwb", memwb_o, '0);
    check("abort_stall", stall_o, 1'b0);
    check("abort_req", dmem_req, 1'b0);
    @(negedge clk);
    reset       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h5555_5555_5555_5555;
    #1;
    check("stale_rvalid_stall", stall_o, 1'b1);
    check("stale_rvalid_req", dmem_req, 1'b1);
    @(posedge clk);
    #1;
    check("stale_rvalid_memwb", memwb_o, '0);
    dmem_rvalid = 1'b0;
    do_reset();

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      run_op(kind,
             (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom),
             {$urandom, $urandom},
             {$urandom, $urandom},
             {$urandom, $urandom},
             $urandom_range(0, 3),
             $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
